seq_shifter: RTL and testbench

//   Parametrised multi-cycle shift/rotate unit; generalises the fixed sl2/sl5 shifters.

---
 rtl/seq_shifter.sv | 119 +++++++++++
 tb/tb_seq_shifter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: shifts a latched operand by up to STEP bits per clock
// (SLL, SRL, SRA, ROL) under a start/busy/done handshake.
module seq_shifter #(
  parameter  int N    = 32,
  parameter  int STEP = 4,
  localparam int SHW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [SHW-1:0] shamt,
  input  logic [N-1:0]   din,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   dout
);

  localparam int REMW = SHW + 1;
  localparam int KW   = $clog2(STEP) + 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_work;
  logic [1:0]      r_mode;
  logic [REMW-1:0] r_rem;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_dout;

  logic [KW-1:0]         w_k;
  logic [STEP:0][N-1:0]  w_cand;
  logic [N-1:0]          w_next;
  logic [REMW-1:0]       w_rem_next;

  // Only amounts 0..STEP are ever applied in one clock, so build just those candidates.
  genvar gi;
  generate
    for (gi = 0; gi <= STEP; gi++) begin : g_cand
      if (gi == 0) begin : g_zero
        assign w_cand[gi] = r_work;
      end else begin : g_shift
        assign w_cand[gi] =
          (r_mode == MODE_SLL) ? (r_work << gi) :
          (r_mode == MODE_SRL) ? (r_work >> gi) :
          (r_mode == MODE_SRA) ? $unsigned($signed(r_work) >>> gi) :
                                 ((r_work << gi) | (r_work >> (N - gi)));
      end
    end
  endgenerate

  assign w_k        = (r_rem >= REMW'(STEP)) ? KW'(STEP) : KW'(r_rem);
  assign w_next     = w_cand[w_k];
  assign w_rem_next = r_rem - REMW'(w_k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_mode  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_work <= din;
            r_mode <= mode;
            r_rem  <= {1'b0, shamt};
            r_busy <= 1'b1;
            if (shamt == '0) begin
              r_dout  <= din;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_next;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_dout  <= w_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (N=32, STEP=4): directed spec cases, random
// operations against a whole-amount reference model, start-hold and mid-operation reset.
module tb_seq_shifter;

  localparam int N    = 32;
  localparam int STEP = 4;
  localparam int SHW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     mode;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   din;
  logic           busy;
  logic           done;
  logic [N-1:0]   dout;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [N-1:0] prev_res = '0;

  always #5 clk = ~clk;

  seq_shifter #(.N(N), .STEP(STEP)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  // Whole shift applied at once; rotate taken from the upper half of a doubled word.
  function automatic logic [N-1:0] ref_shift(input logic [1:0] m, input int s, input logic [N-1:0] d);
    logic [2*N-1:0] dd;
    case (m)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return N'($signed(d) >>> s);
      default: begin
        dd = {d, d} << s;
        return dd[2*N-1:N];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called at #1 after the accept edge; follows the operation until busy drops.
  task automatic observe(input string tag, input logic [1:0] m, input int s, input logic [N-1:0] d);
    int           e, lat, bcnt, dcnt, lat_exp;
    logic         hold_ok;
    logic [N-1:0] exp;
    exp     = ref_shift(m, s, d);
    lat_exp = (s + STEP - 1) / STEP;
    lat = -1; bcnt = 0; dcnt = 0; e = 0; hold_ok = 1'b1;
    while (e < 40) begin
      if (done) begin
        dcnt++;
        if (lat < 0) lat = e;
      end else if (lat < 0 && dout !== prev_res) begin
        hold_ok = 1'b0;
      end
      if (busy) bcnt++;
      else break;
      @(posedge clk); #1;
      e++;
    end
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(lat_exp + 1));
    chk({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
    chk({tag, "_dout_hold"}, 32'(hold_ok), 32'd1);
    $display("op %s mode=%0d shamt=%0d din=%h dout=%h exp=%h lat=%0d", tag, m, s, d, dout, exp, lat);
    prev_res = exp;
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input int s, input logic [N-1:0] d);
    @(negedge clk);
    start = 1'b1; mode = m; shamt = SHW'(s); din = d;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 2'($urandom);
    shamt = SHW'($urandom);
    din   = $urandom;
    observe(tag, m, s, d);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; mode = '0; shamt = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dout", dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("sll_1_5",     2'd0, 5,  32'h00000001);
    run_op("sll_ff_5",    2'd0, 5,  32'hFFFFFFFF);
    run_op("srl_beef_8",  2'd1, 8,  32'h0000BEEF);
    run_op("sra_neg_31",  2'd2, 31, 32'hF0000000);
    run_op("sra_pos_31",  2'd2, 31, 32'h70000000);
    run_op("rol_4",       2'd3, 4,  32'h13579BDF);
    run_op("zero_shamt",  2'd1, 0,  32'hCAFEF00D);
    run_op("rol_31",      2'd3, 31, 32'h80000001);
    run_op("repeat_a",    2'd0, 7,  32'h00F0000F);
    run_op("repeat_b",    2'd0, 7,  32'h00F0000F);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)), $urandom);
    end

    // start held high with changing operands: second request only after busy drops
    @(negedge clk);
    start = 1'b1; mode = 2'd3; shamt = 5'd13; din = 32'h0123ABCD;
    @(posedge clk); #1;
    mode = 2'd1; shamt = 5'd8; din = 32'h89ABCDEF;
    observe("hold_first", 2'd3, 13, 32'h0123ABCD);
    @(posedge clk); #1;
    start = 1'b0;
    observe("hold_second", 2'd1, 8, 32'h89ABCDEF);

    // reset asserted mid-SHIFT
    @(negedge clk);
    start = 1'b1; mode = 2'd2; shamt = 5'd31; din = 32'hF0000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dout", dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("midrst_quiet", 32'(dcnt), 32'd0);
    prev_res = '0;
    run_op("after_rst", 2'd2, 31, 32'hF0000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
